hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline hazard controller for the 5-stage MIPS core. It decides each cycle whether the IF and ID stages advance, stall, or flush, and whether a bubble goes into ID/EX. It covers load-use hazards, branches resolved in ID, and a multi-cycle multiply/divide unit (MDU) tracked by an internal FSM. It sits beside the forwarding unit and drives the PC and IF/ID enables and the ID/EX control-zeroing mux.

## Interface
- MDU_LAT, 4, MDU busy cycles after issue (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- D_rs, D_rt  in  5 each  source registers of the instruction in ID
- D_useRt  in  1  ID instruction reads rt
- D_isBranch  in  1  ID instruction is a branch compared in ID
- D_branchTaken  in  1  ID branch comparator result
- D_mduUse  in  1  ID instruction reads HI/LO or issues an MDU op
- X_writeReg  in  5  destination register in EX
- X_regWrite, X_memRead  in  1 each  EX register write / load
- M_writeReg  in  5  destination register in MEM
- M_memRead  in  1  MEM stage holds a load
- X_mduStart  in  1  MDU op issued from EX this cycle
- pc_en  out  1  PC write enable
- ifid_en  out  1  IF/ID write enable
- ifid_flush  out  1  zero IF/ID on the next edge
- idex_bubble  out  1  zero ID/EX control on the next edge
- mdu_busy  out  1  MDU FSM in BUSY
- stall_cycles  out  32  stall performance count

## Operation
- match(r) = r≠0 && (r==D_rs || (D_useRt && r==D_rt)).
- Stall terms, combinational:
  - H1 load-use: X_memRead && match(X_writeReg).
  - H2 branch-after-ALU: D_isBranch && X_regWrite && !X_memRead && match(X_writeReg).
  - H3 branch-after-load, second cycle: D_isBranch && M_memRead && match(M_writeReg). H1 covers the first cycle.
  - H4 MDU: D_mduUse && (mdu_busy || X_mduStart).
- stall = H1|H2|H3|H4.
- While stall=1: pc_en=0, ifid_en=0, idex_bubble=1.
- While stall=0: pc_en=1, ifid_en=1, idex_bubble=0.
- ifid_flush = D_isBranch && D_branchTaken && !stall. Flush is never raised while stalling, because the compared operands are stale.
- MDU FSM has states IDLE and BUSY, with counter cnt of width clog2(MDU_LAT)+1.
  - IDLE, X_mduStart=1: go to BUSY and load cnt=MDU_LAT-1.
  - BUSY, cnt==0: go to IDLE.
  - BUSY, otherwise: cnt decrements by 1.
  - X_mduStart while BUSY cannot occur (H4 prevents it). If it does occur, it is ignored and cnt is not reloaded.
- mdu_busy = (state==BUSY).

## Timing
- Reset (rst high, asynchronous):
  - FSM goes to IDLE, cnt=0, stall_cycles=0.
  - Outputs are forced to pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0, mdu_busy=0.
- Reset mid-MDU aborts the operation. After rst falls, mdu_busy=0 immediately.
- Stall and flush outputs are combinational and have zero latency from their inputs. The pipeline registers sample them at the next rising edge.
- Stall lengths:
  - H1: exactly 1 cycle.
  - H2: exactly 1 cycle.
  - Load then dependent branch: 2 cycles (H1, then H3).
- MDU timing: X_mduStart at edge-cycle t gives mdu_busy=1 in cycles t+1 … t+MDU_LAT. A dependent D_mduUse held in ID is released in cycle t+MDU_LAT+1.
- Simultaneous events:
  - Any stall term suppresses flush.
  - Multiple stall terms produce a single stall, not additive ones.
  - X_mduStart with D_mduUse in the same cycle stalls via H4.

## Configuration
- HAZ_PERF_CNT_EN defined: stall_cycles increments on every rising edge where stall=1 and rst=0. It saturates at 32'hFFFFFFFF.
- HAZ_PERF_CNT_EN undefined: stall_cycles is a constant 0 and no counter register is built. All other behaviour is identical.

## Test plan
- Reset: assert rst mid-MDU (mdu_busy=1).
  - During rst: pc_en=0, idex_bubble=1, mdu_busy=0.
  - After release: stall_cycles=0.
- Load-use: X_memRead=1, X_writeReg=5, D_rs=5.
  - One cycle of pc_en=0, ifid_en=0, idex_bubble=1, then pc_en=1.
  - Repeat with X_writeReg=0: no stall.
- Load then branch: load $8 in EX; beq with D_rs=8, D_isBranch=1, D_branchTaken=1 in ID.
  - Two stall cycles (H1, then H3) with ifid_flush=0.
  - ifid_flush=1 in the third cycle.
- Branch-after-ALU: X_regWrite=1, X_writeReg=9, D_rt=9, D_useRt=1, D_isBranch=1.
  - One stall cycle.
  - With D_useRt=0: no stall.
- MDU with MDU_LAT=4: X_mduStart at cycle 10, D_mduUse=1 held.
  - mdu_busy=1 in cycles 11–14.
  - Stall in cycles 10–14; pc_en=1 at cycle 15.
- Perf counter (HAZ_PERF_CNT_EN defined): after the above sequence, stall_cycles equals the total number of stall cycles (1+2+1+5=9).

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: ID/EX/MEM hazard inputs and pipeline-control outputs of the hazard unit
interface hazard_control_unit_if;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic        D_useRt;
    logic        D_isBranch;
    logic        D_branchTaken;
    logic        D_mduUse;
    logic [4:0]  X_writeReg;
    logic        X_regWrite;
    logic        X_memRead;
    logic [4:0]  M_writeReg;
    logic        M_memRead;
    logic        X_mduStart;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        mdu_busy;
    logic [31:0] stall_cycles;

    modport master (
        output D_rs, D_rt, D_useRt, D_isBranch, D_branchTaken, D_mduUse,
        output X_writeReg, X_regWrite, X_memRead, M_writeReg, M_memRead, X_mduStart,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, mdu_busy, stall_cycles
    );

    modport slave (
        input  D_rs, D_rt, D_useRt, D_isBranch, D_branchTaken, D_mduUse,
        input  X_writeReg, X_regWrite, X_memRead, M_writeReg, M_memRead, X_mduStart,
        output pc_en, ifid_en, ifid_flush, idex_bubble, mdu_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use/branch/MDU stall and flush control; HAZ_PERF_CNT_EN builds the stall counter
module hazard_control_unit #(
    parameter int MDU_LAT = 4
) (
    input logic             clk,
    input logic             rst,
    hazard_control_unit_if.slave hif
);
    localparam int CW = $clog2(MDU_LAT) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          match_x, match_m, h1, h2, h3, h4, stall;

    assign match_x = hif.X_writeReg != '0 &&
                     (hif.X_writeReg == hif.D_rs || (hif.D_useRt && hif.X_writeReg == hif.D_rt));
    assign match_m = hif.M_writeReg != '0 &&
                     (hif.M_writeReg == hif.D_rs || (hif.D_useRt && hif.M_writeReg == hif.D_rt));

    assign h1    = hif.X_memRead && match_x;
    assign h2    = hif.D_isBranch && hif.X_regWrite && !hif.X_memRead && match_x;
    assign h3    = hif.D_isBranch && hif.M_memRead && match_m;
    assign h4    = hif.D_mduUse && (hif.mdu_busy || hif.X_mduStart);
    assign stall = h1 || h2 || h3 || h4;

    assign hif.pc_en       = !rst && !stall;
    assign hif.ifid_en     = !rst && !stall;
    assign hif.idex_bubble = rst || stall;
    // A stalled branch compared stale operands, so its outcome must not flush.
    assign hif.ifid_flush  = !rst && hif.D_isBranch && hif.D_branchTaken && !stall;
    assign hif.mdu_busy    = state == BUSY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == IDLE) begin
            state_nx = hif.X_mduStart ? BUSY : IDLE;
            cnt_nx   = hif.X_mduStart ? CW'(MDU_LAT - 1) : cnt;
        end else begin
            state_nx = cnt == '0 ? IDLE : BUSY;
            cnt_nx   = cnt == '0 ? cnt : cnt - 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf <= '0;
        else if (stall && perf != 32'hFFFF_FFFF)
            perf <= perf + 32'd1;
    end

    assign hif.stall_cycles = perf;
`else
    assign hif.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed plus random stimulus, scoreboard queue checked by a separate monitor
module tb_hazard_control_unit;
    localparam int MDU_LAT = 4;

    typedef struct packed {
        logic       rst;
        logic [4:0] d_rs, d_rt;
        logic       use_rt, is_br, taken, mdu_use;
        logic [4:0] x_wr;
        logic       x_rw, x_mr;
        logic [4:0] m_wr;
        logic       m_mr, start;
    } stim_t;

    typedef struct {
        logic        pc_en, ifid_en, flush, bubble, busy;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    hazard_control_unit_if hif ();

    hazard_control_unit #(.MDU_LAT(MDU_LAT)) dut (.clk(clk), .rst(rst), .hif(hif));

    always #5 clk = ~clk;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: MDU busy as a window of cycle numbers, stall count as a plain integer.
    int          cyc = 0;
    int          busy_from = 1, busy_end = 0;
    logic [31:0] perf = 0;

    function automatic logic match(input logic [4:0] r, input stim_t s);
        return r != 0 && (r == s.d_rs || (s.use_rt && r == s.d_rt));
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        logic busy, stall;
        @(posedge clk);
        #1;
        cyc++;
        rst               = s.rst;
        hif.D_rs          = s.d_rs;
        hif.D_rt          = s.d_rt;
        hif.D_useRt       = s.use_rt;
        hif.D_isBranch    = s.is_br;
        hif.D_branchTaken = s.taken;
        hif.D_mduUse      = s.mdu_use;
        hif.X_writeReg    = s.x_wr;
        hif.X_regWrite    = s.x_rw;
        hif.X_memRead     = s.x_mr;
        hif.M_writeReg    = s.m_wr;
        hif.M_memRead     = s.m_mr;
        hif.X_mduStart    = s.start;
        if (s.rst) begin
            busy_end = 0;
            busy_from = 1;
            perf = 0;
        end
        busy  = !s.rst && cyc >= busy_from && cyc <= busy_end;
        stall = (s.x_mr && match(s.x_wr, s)) ||
                (s.is_br && s.x_rw && !s.x_mr && match(s.x_wr, s)) ||
                (s.is_br && s.m_mr && match(s.m_wr, s)) ||
                (s.mdu_use && (busy || s.start));
        e.pc_en   = !s.rst && !stall;
        e.ifid_en = !s.rst && !stall;
        e.bubble  = s.rst || stall;
        e.flush   = !s.rst && s.is_br && s.taken && !stall;
        e.busy    = busy;
`ifdef HAZ_PERF_CNT_EN
        e.cnt     = perf;
`else
        e.cnt     = 0;
`endif
        q.push_back(e);
        if (!s.rst && stall && perf != 32'hFFFF_FFFF)
            perf++;
        if (!s.rst && s.start && !busy) begin
            busy_from = cyc + 1;
            busy_end  = cyc + MDU_LAT;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("pc_en", 32'(hif.pc_en), 32'(e.pc_en));
                check("ifid_en", 32'(hif.ifid_en), 32'(e.ifid_en));
                check("ifid_flush", 32'(hif.ifid_flush), 32'(e.flush));
                check("idex_bubble", 32'(hif.idex_bubble), 32'(e.bubble));
                check("mdu_busy", 32'(hif.mdu_busy), 32'(e.busy));
                check("stall_cycles", hif.stall_cycles, e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        s = '0;
        hif.D_rs = 0; hif.D_rt = 0; hif.D_useRt = 0; hif.D_isBranch = 0;
        hif.D_branchTaken = 0; hif.D_mduUse = 0; hif.X_writeReg = 0; hif.X_regWrite = 0;
        hif.X_memRead = 0; hif.M_writeReg = 0; hif.M_memRead = 0; hif.X_mduStart = 0;
        s.rst = 1;
        apply(s);
        apply(s);
        // Reset in the middle of an MDU operation.
        s = '0; s.start = 1;
        apply(s);
        s = '0;
        apply(s);
        apply(s);
        s.rst = 1;
        apply(s);
        s = '0;
        apply(s);
        apply(s);
        // Load-use, then with $0 destination.
        s = '0; s.x_mr = 1; s.x_wr = 5; s.d_rs = 5;
        apply(s);
        s = '0; s.m_mr = 1; s.m_wr = 5; s.d_rs = 5;
        apply(s);
        s = '0; s.x_mr = 1; s.x_wr = 0; s.d_rs = 0;
        apply(s);
        // Load then dependent taken branch.
        s = '0; s.x_mr = 1; s.x_wr = 8; s.d_rs = 8; s.is_br = 1; s.taken = 1;
        apply(s);
        s = '0; s.m_mr = 1; s.m_wr = 8; s.d_rs = 8; s.is_br = 1; s.taken = 1;
        apply(s);
        s = '0; s.d_rs = 8; s.is_br = 1; s.taken = 1;
        apply(s);
        // Branch after ALU on rt, then with rt unused.
        s = '0; s.x_rw = 1; s.x_wr = 9; s.d_rt = 9; s.use_rt = 1; s.is_br = 1;
        apply(s);
        s = '0; s.d_rt = 9; s.use_rt = 1; s.is_br = 1;
        apply(s);
        s = '0; s.x_rw = 1; s.x_wr = 9; s.d_rt = 9; s.use_rt = 0; s.is_br = 1;
        apply(s);
        // MDU issue with a dependent instruction held in ID.
        s = '0; s.start = 1; s.mdu_use = 1;
        apply(s);
        s.start = 0;
        for (int i = 0; i < MDU_LAT + 2; i++) apply(s);
        // Randomized traffic on a small register set to make matches common.
        for (int i = 0; i < 800; i++) begin
            s = '0;
            s.rst     = $urandom_range(0, 63) == 0;
            s.d_rs    = 5'($urandom_range(0, 3));
            s.d_rt    = 5'($urandom_range(0, 3));
            s.use_rt  = 1'($urandom);
            s.is_br   = 1'($urandom);
            s.taken   = 1'($urandom);
            s.mdu_use = $urandom_range(0, 3) == 0;
            s.x_wr    = 5'($urandom_range(0, 3));
            s.x_rw    = 1'($urandom);
            s.x_mr    = $urandom_range(0, 3) == 0;
            s.m_wr    = 5'($urandom_range(0, 3));
            s.m_mr    = $urandom_range(0, 3) == 0;
            s.start   = $urandom_range(0, 7) == 0;
            apply(s);
        end
        @(posedge clk);
        @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
